fc_sequencer: RTL and testbench
===============================

FC_SEQUENCER -- requirements
Module: fc_sequencer

Interface
REQ-001 SHALL have parameter INPUT_NUM, default 48, number of buffered FC inputs.
REQ-002 SHALL have parameter OUTPUT_NUM, default 10, number of output neurons/classes.
REQ-003 SHALL have parameter INPUT_WIDTH, default 16, number of input triplets per frame.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port valid_in, input, 1, triplet present on the data_in_* ports.
REQ-007 SHALL have ports data_in_1, data_in_2, data_in_3, input, 12 each, signed pooled features.
REQ-008 SHALL have port ready_in, output, 1, triplet accepted this cycle if valid_in is high.
REQ-009 SHALL have port w_addr, output, 9, weight ROM address, computed as out_idx*INPUT_NUM+in_idx.
REQ-010 SHALL have port w_data, input, 8, signed ROM word, valid one cycle after w_addr.
REQ-011 SHALL have port b_fc, input, 80 [0:79], eight-bit signed biases, neuron k at bits [8k+:8].
REQ-012 SHALL have port data_out, output, 12, neuron result.
REQ-013 SHALL have port valid_out_fc, output, 1, one-cycle strobe qualifying data_out.
REQ-014 SHALL have port class_out, output, 4, argmax neuron index.
REQ-015 SHALL have port class_valid, output, 1, one-cycle strobe qualifying class_out.

Function
REQ-016 SHALL use the states LOAD, MAC, EMIT and DONE.
REQ-017 LOAD: ready_in=1; each valid_in stores data_in_1/2/3 at buffer index j, 16+j and 32+j, sign-extended to 14 bits; j runs 0..15.
REQ-018 LOAD: when j=15 is accepted, the block SHALL go to MAC with out_idx=0 and in_idx=0; ready_in=0 in every state except LOAD.
REQ-019 valid_in outside LOAD SHALL be ignored, with no buffer write and no counter change.
REQ-020 MAC entry: the 20-bit signed accumulator SHALL be loaded with the sign-extended bias[out_idx].
REQ-021 MAC: w_addr SHALL be issued for in_idx 0..47, one address per cycle.
REQ-022 MAC: the product w_data*buffer[in_idx] SHALL be added one cycle after the address is issued, using a registered copy of the buffer operand.
REQ-023 The accumulator SHALL wrap in two's complement; there is no saturation.
REQ-024 After the last product (49 cycles after MAC entry) the block SHALL go to EMIT.
REQ-025 EMIT: data_out = acc[18:7] and valid_out_fc=1 for exactly one cycle.
REQ-026 EMIT: the argmax SHALL update if acc > max (signed), or unconditionally for neuron 0; ties keep the lower index.
REQ-027 EMIT: if out_idx < OUTPUT_NUM-1, the block SHALL increment out_idx and return to MAC; otherwise it goes to DONE.
REQ-028 DONE: class_out = argmax index and class_valid=1 for one cycle, then the block goes to LOAD with j=0.
REQ-029 Per-neuron latency SHALL be 50 cycles; last triplet accepted to class_valid SHALL be 501 cycles.
REQ-030 valid_out_fc and class_valid SHALL never be high in the same cycle.
REQ-031 w_addr SHALL hold its last value outside MAC.

Reset
REQ-032 On a clk edge with rst_n=0, the block SHALL go to LOAD with j, out_idx, in_idx, acc and max cleared.
REQ-033 On the same edge, data_out=0, valid_out_fc=0, class_out=0, class_valid=0, w_addr=0, and ready_in=1 after reset.
REQ-034 Reset in any state, including mid-MAC, SHALL abort the frame with no further strobes.
REQ-035 The buffer SHALL not be reset; the next frame overwrites it.

Structure
REQ-036 Package fc_pkg SHALL hold INPUT_NUM, OUTPUT_NUM, INPUT_WIDTH, the data/weight/acc widths, the output slice [18:7] and the state encoding.
REQ-037 One sub-module, fc_mac, SHALL contain the registered operand, 14x8 signed multiply, 20-bit accumulate, bias load and clear.
REQ-038 Sequencing, buffer and argmax SHALL stay in fc_sequencer.

Verification
REQ-039 All inputs 1, all weights 1, bias 0 -> ten strobes with data_out=0 (acc=48), class_out=0.
REQ-040 Inputs 128, neuron 7 weights 2, others 1, biases 0 -> neuron 7 data_out=96, others 48; class_out=7; class_valid 501 cycles after the last triplet.
REQ-041 Neurons 3 and 5 tie at the maximum -> class_out=3.
REQ-042 Input -2048 (12'h800), weight -128, bias -128 -> product sign-extension is correct and acc wraps mod 2^20 against the reference model.
REQ-043 Hold valid_in high through MAC/EMIT with changing data -> buffer unchanged, results unchanged, and ready_in=0 until LOAD.
REQ-044 Pulse rst_n low at cycle 200 of MAC, then send a fresh frame -> no stale strobes, and correct ten outputs plus class.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared constants, widths and state encoding for the fully-connected sequencer.
package fc_pkg;

  localparam int FC_INPUT_NUM   = 48;
  localparam int FC_OUTPUT_NUM  = 10;
  localparam int FC_INPUT_WIDTH = 16;

  localparam int DATA_W   = 12;
  localparam int BUF_W    = 14;
  localparam int WEIGHT_W = 8;
  localparam int BIAS_W   = 8;
  localparam int ACC_W    = 20;
  localparam int PROD_W   = BUF_W + WEIGHT_W;
  localparam int ADDR_W   = 9;
  localparam int CLS_W    = 4;
  localparam int OUT_HI   = 18;
  localparam int OUT_LO   = 7;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_MAC,
    ST_EMIT,
    ST_DONE
  } state_t;

  // First weight-ROM address of a neuron's row.
  function automatic logic [ADDR_W-1:0] rom_base(input int out_idx, input int in_num);
    return ADDR_W'(out_idx * in_num);
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Registered-operand 14x8 signed multiply-accumulate with bias load and clear.
module fc_mac
  import fc_pkg::*;
(
  input  logic                       clk,
  input  logic                       i_clear,
  input  logic                       i_load,
  input  logic                       i_add,
  input  logic signed [BUF_W-1:0]    i_operand,
  input  logic signed [WEIGHT_W-1:0] i_weight,
  input  logic signed [BIAS_W-1:0]   i_bias,
  output logic signed [ACC_W-1:0]    o_acc
);

  logic signed [BUF_W-1:0]  r_op;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [PROD_W-1:0] w_prod;

  assign w_prod = r_op * i_weight;
  assign o_acc  = r_acc;

  // NOTE: the operand register is overwritten before every use, so it carries no reset.
  always_ff @(posedge clk) begin
    r_op <= i_operand;
  end

  // Truncating the product to the accumulator width gives the same result mod 2^20.
  always_ff @(posedge clk) begin
    if (i_clear)     r_acc <= '0;
    else if (i_load) r_acc <= ACC_W'(i_bias);
    else if (i_add)  r_acc <= r_acc + w_prod[ACC_W-1:0];
  end

endmodule

// File: rtl/fc_sequencer.sv
// Buffers one frame of pooled features, runs one MAC pass per output neuron
// against an external weight ROM, and reports every neuron result plus the argmax.
module fc_sequencer
  import fc_pkg::*;
#(
  parameter int INPUT_NUM   = FC_INPUT_NUM,
  parameter int OUTPUT_NUM  = FC_OUTPUT_NUM,
  parameter int INPUT_WIDTH = FC_INPUT_WIDTH
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic [DATA_W-1:0]            data_in_1,
  input  logic [DATA_W-1:0]            data_in_2,
  input  logic [DATA_W-1:0]            data_in_3,
  output logic                         ready_in,
  output logic [ADDR_W-1:0]            w_addr,
  input  logic [WEIGHT_W-1:0]          w_data,
  input  logic [0:BIAS_W*OUTPUT_NUM-1] b_fc,
  output logic [DATA_W-1:0]            data_out,
  output logic                         valid_out_fc,
  output logic [CLS_W-1:0]             class_out,
  output logic                         class_valid
);

  localparam int J_W  = $clog2(INPUT_WIDTH);
  localparam int IN_W = $clog2(INPUT_NUM + 1);

  logic signed [BUF_W-1:0] r_buf [INPUT_NUM];
  state_t                  r_state;
  logic [J_W-1:0]          r_j;
  logic [CLS_W-1:0]        r_out_idx;
  logic [IN_W-1:0]         r_in_idx;
  logic signed [ACC_W-1:0] r_max;
  logic [CLS_W-1:0]        r_arg;
  logic                    r_ready;
  logic [ADDR_W-1:0]       r_w_addr;
  logic [DATA_W-1:0]       r_data_out;
  logic                    r_valid_fc;
  logic [CLS_W-1:0]        r_class;
  logic                    r_class_valid;

  logic                    w_accept_last;
  logic                    w_next_neuron;
  logic                    w_load;
  logic                    w_add;
  logic [CLS_W-1:0]        w_bias_idx;
  logic [BIAS_W-1:0]       w_bias_raw;
  logic signed [BUF_W-1:0] w_operand;
  logic signed [ACC_W-1:0] w_acc;

  assign w_accept_last = (r_state == ST_LOAD) && valid_in && (r_j == J_W'(INPUT_WIDTH - 1));
  assign w_next_neuron = (r_state == ST_EMIT) && (r_out_idx != CLS_W'(OUTPUT_NUM - 1));
  assign w_load        = w_accept_last || w_next_neuron;
  // The first MAC cycle has no ROM word yet; products trail addresses by one cycle.
  assign w_add         = (r_state == ST_MAC) && (r_in_idx != '0);
  assign w_bias_idx    = (r_state == ST_EMIT) ? r_out_idx + 1'b1 : '0;
  assign w_bias_raw    = b_fc[BIAS_W*w_bias_idx +: BIAS_W];
  assign w_operand     = (r_in_idx < IN_W'(INPUT_NUM)) ? r_buf[r_in_idx] : '0;

  fc_mac u_mac (
    .clk       (clk),
    .i_clear   (!rst_n),
    .i_load    (w_load),
    .i_add     (w_add),
    .i_operand (w_operand),
    .i_weight  ($signed(w_data)),
    .i_bias    ($signed(w_bias_raw)),
    .o_acc     (w_acc)
  );

  // NOTE: the feature buffer is a memory with no reset; each frame rewrites all of it.
  always_ff @(posedge clk) begin
    if (rst_n && r_state == ST_LOAD && valid_in) begin
      r_buf[r_j]                   <= {{(BUF_W-DATA_W){data_in_1[DATA_W-1]}}, data_in_1};
      r_buf[INPUT_WIDTH + r_j]     <= {{(BUF_W-DATA_W){data_in_2[DATA_W-1]}}, data_in_2};
      r_buf[2*INPUT_WIDTH + r_j]   <= {{(BUF_W-DATA_W){data_in_3[DATA_W-1]}}, data_in_3};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_LOAD;
      r_j           <= '0;
      r_out_idx     <= '0;
      r_in_idx      <= '0;
      r_max         <= '0;
      r_arg         <= '0;
      r_ready       <= 1'b1;
      r_w_addr      <= '0;
      r_data_out    <= '0;
      r_valid_fc    <= 1'b0;
      r_class       <= '0;
      r_class_valid <= 1'b0;
    end else begin
      r_valid_fc    <= 1'b0;
      r_class_valid <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (valid_in) begin
            r_j <= r_j + 1'b1;
            if (w_accept_last) begin
              r_state   <= ST_MAC;
              r_j       <= '0;
              r_out_idx <= '0;
              r_in_idx  <= '0;
              r_ready   <= 1'b0;
              r_w_addr  <= rom_base(0, INPUT_NUM);
            end
          end
        end
        ST_MAC: begin
          if (r_in_idx == IN_W'(INPUT_NUM)) begin
            r_state <= ST_EMIT;
          end else begin
            r_in_idx <= r_in_idx + 1'b1;
            if (r_in_idx < IN_W'(INPUT_NUM - 1)) r_w_addr <= r_w_addr + 1'b1;
          end
        end
        ST_EMIT: begin
          r_data_out <= w_acc[OUT_HI:OUT_LO];
          r_valid_fc <= 1'b1;
          if (r_out_idx == '0 || w_acc > r_max) begin
            r_max <= w_acc;
            r_arg <= r_out_idx;
          end
          if (w_next_neuron) begin
            r_out_idx <= r_out_idx + 1'b1;
            r_in_idx  <= '0;
            r_state   <= ST_MAC;
            r_w_addr  <= rom_base(int'(r_out_idx) + 1, INPUT_NUM);
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_class       <= r_arg;
          r_class_valid <= 1'b1;
          r_ready       <= 1'b1;
          r_j           <= '0;
          r_state       <= ST_LOAD;
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign ready_in     = r_ready;
  assign w_addr       = r_w_addr;
  assign data_out     = r_data_out;
  assign valid_out_fc = r_valid_fc;
  assign class_out    = r_class;
  assign class_valid  = r_class_valid;

endmodule

// File: tb/tb_fc_sequencer.sv
// Scoreboard bench for fc_sequencer: a reference model fills expectation queues
// when a frame is sent, and strobes are popped and compared as they appear.
module tb_fc_sequencer;

  localparam int IN_N  = 48;
  localparam int OUT_N = 10;
  localparam int IW    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [11:0] data_in_1 = '0, data_in_2 = '0, data_in_3 = '0;
  logic        ready_in;
  logic [8:0]  w_addr;
  logic [7:0]  w_data;
  logic [0:79] b_fc = '0;
  logic [11:0] data_out;
  logic        valid_out_fc;
  logic [3:0]  class_out;
  logic        class_valid;

  fc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .data_in_1    (data_in_1),
    .data_in_2    (data_in_2),
    .data_in_3    (data_in_3),
    .ready_in     (ready_in),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .b_fc         (b_fc),
    .data_out     (data_out),
    .valid_out_fc (valid_out_fc),
    .class_out    (class_out),
    .class_valid  (class_valid)
  );

  always #5 clk = ~clk;

  // Synchronous weight ROM: word appears one cycle after its address.
  logic [7:0] rom [512];
  always @(posedge clk) w_data <= rom[w_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [11:0] data; int t; } exp_fc_t;
  typedef struct { logic [3:0]  cls;  int t; } exp_cls_t;
  exp_fc_t  q_fc[$];
  exp_cls_t q_cls[$];

  int din [3][IW];
  int bias [OUT_N];
  int n_pass  = 0;
  int n_total = 0;
  bit busy    = 1'b0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic apply_bias();
    for (int k = 0; k < OUT_N; k++) b_fc[8*k +: 8] = 8'(bias[k]);
  endtask

  // Reference model: 20-bit wrapped dot product plus bias, slice [18:7], signed argmax.
  task automatic push_expected(input int t_acc);
    longint   a;
    logic [19:0] acc20;
    int       sacc, best;
    int       best_idx;
    exp_fc_t  e;
    exp_cls_t c;
    best = 0;
    best_idx = 0;
    for (int k = 0; k < OUT_N; k++) begin
      a = longint'(bias[k]);
      for (int i = 0; i < IN_N; i++)
        a += longint'($signed(rom[k*IN_N + i])) * longint'(din[i/IW][i%IW]);
      acc20 = a[19:0];
      sacc  = int'($signed(acc20));
      e.data = acc20[18:7];
      e.t    = t_acc + 50*(k+1);
      q_fc.push_back(e);
      if (k == 0 || sacc > best) begin
        best = sacc;
        best_idx = k;
      end
    end
    c.cls = 4'(best_idx);
    c.t   = t_acc + 501;
    q_cls.push_back(c);
  endtask

  task automatic tick();
    exp_fc_t  e;
    exp_cls_t c;
    @(negedge clk);
    if (valid_out_fc && class_valid) check("strobe_overlap", class_valid, 0);
    if (valid_out_fc) begin
      if (q_fc.size() == 0) check("stray_fc", valid_out_fc, 0);
      else begin
        e = q_fc.pop_front();
        check("data_out", data_out, e.data);
        check("fc_time", cyc, e.t);
      end
    end
    if (class_valid) begin
      if (q_cls.size() == 0) check("stray_class", class_valid, 0);
      else begin
        c = q_cls.pop_front();
        check("class_out", class_out, c.cls);
        check("class_time", cyc, c.t);
        check("ready_after_done", ready_in, 1);
        busy = 1'b0;
      end
    end else if (busy) begin
      check("ready_busy", ready_in, 0);
    end
  endtask

  task automatic drive_frame();
    for (int j = 0; j < IW; j++) begin
      tick();
      check("ready_load", ready_in, 1);
      valid_in  = 1'b1;
      data_in_1 = 12'(din[0][j]);
      data_in_2 = 12'(din[1][j]);
      data_in_3 = 12'(din[2][j]);
      if (j == IW-1) begin
        push_expected(cyc + 1);
        busy = 1'b1;
      end
    end
  endtask

  task automatic wait_frame(input bit hold);
    int n = 0;
    while (busy && n < 700) begin
      tick();
      if (busy && hold) begin
        valid_in  = 1'b1;
        data_in_1 = 12'($urandom);
        data_in_2 = 12'($urandom);
        data_in_3 = 12'($urandom);
      end else begin
        valid_in = 1'b0;
      end
      n++;
    end
    valid_in = 1'b0;
    if (busy) begin
      check("frame_timeout", busy, 0);
      busy = 1'b0;
      q_fc.delete();
      q_cls.delete();
    end
  endtask

  task automatic reset_checks();
    check("rst_data_out", data_out, 0);
    check("rst_valid_fc", valid_out_fc, 0);
    check("rst_class_out", class_out, 0);
    check("rst_class_valid", class_valid, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_ready", ready_in, 1);
  endtask

  task automatic fill_inputs(input int v);
    for (int s = 0; s < 3; s++) for (int j = 0; j < IW; j++) din[s][j] = v;
  endtask

  task automatic fill_rom(input int v);
    for (int i = 0; i < 512; i++) rom[i] = (i < OUT_N*IN_N) ? 8'(v) : 8'h00;
  endtask

  task automatic fill_bias(input int v);
    for (int k = 0; k < OUT_N; k++) bias[k] = v;
    apply_bias();
  endtask

  task automatic randomize_frame();
    for (int s = 0; s < 3; s++)
      for (int j = 0; j < IW; j++) din[s][j] = int'($urandom_range(0, 4095)) - 2048;
    for (int i = 0; i < OUT_N*IN_N; i++) rom[i] = 8'($urandom);
    for (int k = 0; k < OUT_N; k++) bias[k] = int'($urandom_range(0, 255)) - 128;
    apply_bias();
  endtask

  initial begin
    fill_rom(0);
    fill_inputs(0);
    fill_bias(0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    // All ones: acc = 48 per neuron, slice gives 0, argmax stays at neuron 0.
    fill_inputs(1);
    fill_rom(1);
    fill_bias(0);
    drive_frame();
    wait_frame(1'b0);

    // Inputs 128, neuron 7 weighted double: 96 versus 48, class 7.
    fill_inputs(128);
    fill_rom(1);
    for (int i = 0; i < IN_N; i++) rom[7*IN_N + i] = 8'd2;
    drive_frame();
    wait_frame(1'b0);

    // Neurons 3 and 5 tie at the maximum: lower index wins.
    fill_rom(1);
    for (int i = 0; i < IN_N; i++) begin
      rom[3*IN_N + i] = 8'd2;
      rom[5*IN_N + i] = 8'd2;
    end
    drive_frame();
    wait_frame(1'b0);

    // Most negative input, weight and bias: sign extension and 20-bit wrap.
    fill_inputs(-2048);
    fill_rom(-128);
    fill_bias(-128);
    drive_frame();
    wait_frame(1'b0);

    // Random frame while valid_in stays high with junk through MAC and EMIT.
    randomize_frame();
    drive_frame();
    wait_frame(1'b1);

    // Reset in the middle of MAC, then make sure nothing stale comes out.
    randomize_frame();
    drive_frame();
    repeat (200) begin
      tick();
      valid_in = 1'b0;
    end
    busy = 1'b0;
    q_fc.delete();
    q_cls.delete();
    rst_n = 1'b0;
    tick();
    reset_checks();
    rst_n = 1'b1;
    repeat (600) tick();

    randomize_frame();
    drive_frame();
    wait_frame(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
